// File: rtl/ram_fifo_pkg.sv
// Shared types and defaults for the RAM-backed FIFO controller.
// The RAM port performs exactly one of these operations per cycle.
package ram_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } ram_op_t;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 2;

endpackage

// File: rtl/ram2x8.sv
// Single-port 2x8 RAM: synchronous write, combinational read at the addressed word.
// Contents are cleared by the shared active-low reset.
module ram2x8 (
    input  logic       clk,
    input  logic       clr,
    input  logic       rw,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] mem [2];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else if (rw) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/ram_fifo_ptr.sv
// Write/read pointer pair and RAM occupancy counter for the FIFO controller.
// Pointers wrap naturally because DEPTH is a power of two.
module ram_fifo_ptr #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          inc_wr,
    input  logic          inc_rd,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (inc_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (inc_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // The controller never issues both in one cycle; treat that as a no-op on count.
        unique case ({inc_wr, inc_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO built on a single-port RAM plus a one-word output register.
// Each cycle the RAM port is given to a read (refill output register) or a write.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ram_rw,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    ram_op_t          op;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             oreg_free;
    logic             take;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;

    assign take      = out_valid_q & out_ready;
    assign oreg_free = ~out_valid_q | out_ready;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0) & ~out_valid_q;

    // Refilling the output register wins over accepting input; nothing moves during reset.
    always_comb begin
        op = OP_IDLE;
        if (clr) begin
            if (oreg_free && (count != '0)) begin
                op = OP_READ;
            end else if (in_valid && !full) begin
                op = OP_WRITE;
            end
        end
    end

    assign ram_rw   = (op == OP_WRITE);
    assign in_ready = (op == OP_WRITE);
    assign ram_addr = (op == OP_WRITE) ? wr_ptr : rd_ptr;
    assign ram_din  = in_data;

    ram_fifo_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr (
        .clk    (clk),
        .clr    (clr),
        .inc_wr (op == OP_WRITE),
        .inc_rd (op == OP_READ),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (op == OP_READ) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_dout;
        end else if (take) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl driving a ram2x8 on its RAM port.
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       ram_rw;
    logic       ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic [1:0] count;
    logic       full;
    logic       empty;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] stim [8];

    ram_fifo_ctrl #(.WIDTH(8), .DEPTH(2)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    ram2x8 u_ram (
        .clk  (clk),
        .clr  (clr),
        .rw   (ram_rw),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push three words with the consumer stalled, leaving the first in the output register.
    task automatic fill3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] w [3];
        w[0] = a; w[1] = b; w[2] = c;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int guard;
            logic acc;
            guard = 0;
            acc = 1'b0;
            in_valid = 1'b1;
            in_data  = w[k];
            while (!acc && guard < 10) begin
                #1;
                acc = in_ready;
                step();
                guard++;
            end
            if (!acc) begin
                n_cmp++; n_err++;
                $display("FAIL fill_timeout word=%0d got in_ready never high, want high", k);
            end
        end
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 2'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got ov=%b cnt=%0d empty=%b full=%b want 0 0 1 0", out_valid, count, empty, full);
        end
        in_valid = 1'b1; in_data = 8'h99;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || ram_rw !== 1'b0 || ram_addr !== 1'b0 || out_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs got rdy=%b rw=%b addr=%b od=%h want 0 0 0 00", in_ready, ram_rw, ram_addr, out_data);
        end
        in_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || ram_rw !== 1'b1) begin
            n_err++;
            $display("FAIL single_write got rdy=%b rw=%b want 1 1", in_ready, ram_rw);
        end
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (ram_rw !== 1'b0 || in_ready !== 1'b0 || count !== 2'd1) begin
            n_err++;
            $display("FAIL single_read_cycle got rw=%b rdy=%b cnt=%0d want 0 0 1", ram_rw, in_ready, count);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hAA || count !== 2'd0) begin
            n_err++;
            $display("FAIL single_out got ov=%b od=%h cnt=%0d want 1 aa 0", out_valid, out_data, count);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL single_drained got ov=%b empty=%b want 0 1", out_valid, empty);
        end
        $display("test_single out=%h", out_data);
    endtask

    task automatic drain_check(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input string tag);
        logic [7:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== e[k]) begin
                n_err++;
                $display("FAIL %s_drain%0d got ov=%b od=%h want 1 %h", tag, k, out_valid, out_data, e[k]);
            end
            step();
        end
        n_cmp++;
        if (empty !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_empty got empty=%b ov=%b want 1 0", tag, empty, out_valid);
        end
        $display("%s drained", tag);
    endtask

    task automatic test_fill();
        fill3(8'hAA, 8'h55, 8'h11);
        in_valid = 1'b1; in_data = 8'h22;
        #1;
        n_cmp++;
        if (count !== 2'd2 || full !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'hAA || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fill_full got cnt=%0d full=%b rdy=%b od=%h ov=%b want 2 1 0 aa 1", count, full, in_ready, out_data, out_valid);
        end
        drain_check(8'hAA, 8'h55, 8'h11, "fill");
    endtask

    task automatic test_backpressure();
        fill3(8'h31, 8'h32, 8'h33);
        in_valid = 1'b1; in_data = 8'hEE;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || ram_rw !== 1'b0 || full !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d got rdy=%b rw=%b full=%b want 0 0 1", k, in_ready, ram_rw, full);
            end
            step();
        end
        drain_check(8'h31, 8'h32, 8'h33, "bp");
    endtask

    task automatic run_stream(input int n, input bit toggle, input string tag);
        int sent, got, cyc;
        logic acc;
        sent = 0; got = 0; cyc = 0;
        in_valid = 1'b1; in_data = stim[0]; out_ready = 1'b1;
        while (got < n && cyc < 200) begin
            #1;
            if ((!out_valid || out_ready) && count != 2'd0) begin
                n_cmp++;
                if (in_ready !== 1'b0 || ram_rw !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_read_cycle got rdy=%b rw=%b want 0 0", tag, in_ready, ram_rw);
                end
            end
            if (count > 2'd2) begin
                n_cmp++; n_err++;
                $display("FAIL %s_count_range got %0d want <=2", tag, count);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_data !== stim[got]) begin
                    n_err++;
                    $display("FAIL %s_order idx=%0d got %h want %h", tag, got, out_data, stim[got]);
                end else begin
                    $display("%s out[%0d]=%h", tag, got, out_data);
                end
                got++;
            end
            step();
            cyc++;
            if (acc) sent++;
            in_valid = (sent < n);
            in_data  = stim[sent % 8];
            if (toggle) out_ready = ~out_ready;
        end
        n_cmp++;
        if (got != n || sent != n) begin
            n_err++;
            $display("FAIL %s_complete got sent=%0d recv=%0d want %0d", tag, sent, got, n);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL %s_final_empty got %b want 1", tag, empty);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 8; k++) stim[k] = 8'(k + 1);
        run_stream(6, 1'b0, "wrap");
    endtask

    task automatic test_contention();
        for (int k = 0; k < 8; k++) stim[k] = 8'(8'hC0 + k);
        run_stream(6, 1'b1, "contention");
    endtask

    task automatic test_reset_midstream();
        fill3(8'hD1, 8'hD2, 8'hD3);
        in_valid = 1'b1; in_data = 8'h44;
        @(negedge clk);
        #2;
        clr = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 2'd0 || empty !== 1'b1 || ram_addr !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset got ov=%b cnt=%0d empty=%b addr=%b rdy=%b want 0 0 1 0 0", out_valid, count, empty, ram_addr, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        step();
        in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            n_err++;
            $display("FAIL midreset_newdata got ov=%b od=%h want 1 77", out_valid, out_data);
        end
        step();
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_empty got %b want 1", empty);
        end
        $display("test_reset_midstream out=77 check done");
    endtask

    initial begin
        clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        for (int k = 0; k < 8; k++) stim[k] = 8'h00;
        #12;
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_wrap();
        test_contention();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
